mem_arbiter: RTL and testbench

//  Shares the single AXI memory port between I-cache refill and D-cache refill/write-back.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_watchdog.sv | 54 +++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the memory-port arbiter.
// ARB_ROUND_ROBIN_EN (used by mem_arbiter) switches tie-breaking to round robin.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_ICACHE,
    OWN_DCACHE
  } owner_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  // Counter must be able to hold the limit itself, so size for timeout + 1 values.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int unsigned WD_CNT_W = wd_width(TIMEOUT_CYCLES_DEFAULT);

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts while enabled, raises a sticky error at the limit.
// A limit of 0 removes the counter entirely and ties the error low.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = WD_CNT_W
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_err
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{i_clk, i_arst, i_clear, i_count_en};
      assign o_err     = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYCLES);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             err_q;

      // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
      always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
          cnt_d = '0;
        end else if (i_count_en && (cnt_q != Limit)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          if (cnt_d == Limit) begin
            err_q <= 1'b1;
          end
        end
      end

      assign o_err = err_q;
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refills/write-backs onto one AXI port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed D-over-I priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_icache_req,
  input  logic [ADDR_W-1:0] i_icache_addr,
  input  logic              i_dcache_req,
  input  logic              i_dcache_we,
  input  logic [ADDR_W-1:0] i_dcache_addr,
  input  logic              i_axi_read_done,
  input  logic              i_axi_write_done,
  output logic              o_axi_read_start,
  output logic              o_axi_write_start,
  output logic [ADDR_W-1:0] o_axi_addr,
  output logic              o_icache_done,
  output logic              o_dcache_done,
  output logic              o_icache_grant,
  output logic              o_dcache_grant,
  output logic              o_timeout_err
);

  state_t            state_q;
  owner_t            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic              read_start_q, write_start_q;
  logic              icache_done_q, dcache_done_q;

  owner_t            winner, tie_winner;
  logic              win_we;
  logic              done_match;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_q;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      last_q <= OWN_ICACHE;
    end else if (state_q == START) begin
      last_q <= owner_q;
    end
  end

  assign tie_winner = (last_q == OWN_DCACHE) ? OWN_ICACHE : OWN_DCACHE;
`else
  assign tie_winner = OWN_DCACHE;
`endif

  always_comb begin
    winner = OWN_NONE;
    if (i_icache_req && i_dcache_req) begin
      winner = tie_winner;
    end else if (i_dcache_req) begin
      winner = OWN_DCACHE;
    end else if (i_icache_req) begin
      winner = OWN_ICACHE;
    end
  end

  assign win_we     = (winner == OWN_DCACHE) && i_dcache_we;
  // Only the done matching the latched direction may end the grant.
  assign done_match = we_q ? i_axi_write_done : i_axi_read_done;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q       <= IDLE;
      owner_q       <= OWN_NONE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      read_start_q  <= 1'b0;
      write_start_q <= 1'b0;
      icache_done_q <= 1'b0;
      dcache_done_q <= 1'b0;
    end else begin
      read_start_q  <= 1'b0;
      write_start_q <= 1'b0;
      icache_done_q <= 1'b0;
      dcache_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winner != OWN_NONE) begin
            owner_q       <= winner;
            we_q          <= win_we;
            addr_q        <= (winner == OWN_DCACHE) ? i_dcache_addr : i_icache_addr;
            read_start_q  <= !win_we;
            write_start_q <= win_we;
            state_q       <= START;
          end
        end
        START, BUSY: begin
          if (done_match) begin
            icache_done_q <= (owner_q == OWN_ICACHE);
            dcache_done_q <= (owner_q == OWN_DCACHE);
            state_q       <= RELEASE;
          end else begin
            state_q <= BUSY;
          end
        end
        RELEASE: begin
          owner_q <= OWN_NONE;
          we_q    <= 1'b0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (wd_width(TIMEOUT_CYCLES))
  ) u_watchdog (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_clear    (state_q == START),
    .i_count_en (state_q == BUSY),
    .o_err      (o_timeout_err)
  );

  assign o_axi_read_start  = read_start_q;
  assign o_axi_write_start = write_start_q;
  assign o_axi_addr        = addr_q;
  assign o_icache_done     = icache_done_q;
  assign o_dcache_done     = dcache_done_q;
  assign o_icache_grant    = (owner_q == OWN_ICACHE);
  assign o_dcache_grant    = (owner_q == OWN_DCACHE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN so the same bench covers both arbitration policies.
module tb_mem_arbiter;

  localparam int TMO   = 8;
  localparam int WHO_I = 1;
  localparam int WHO_D = 2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        arst;
  logic        icache_req, dcache_req, dcache_we;
  logic [63:0] icache_addr, dcache_addr;
  logic        read_done, write_done;
  logic        o_axi_read_start, o_axi_write_start;
  logic [63:0] o_axi_addr;
  logic        o_icache_done, o_dcache_done;
  logic        o_icache_grant, o_dcache_grant;
  logic        o_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: who is requesting, who won last, whether the watchdog has fired.
  bit i_pend, d_pend;
  int last_win;
  bit exp_err;

  mem_arbiter #(
    .ADDR_W         (64),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk             (clk),
    .i_arst            (arst),
    .i_icache_req      (icache_req),
    .i_icache_addr     (icache_addr),
    .i_dcache_req      (dcache_req),
    .i_dcache_we       (dcache_we),
    .i_dcache_addr     (dcache_addr),
    .i_axi_read_done   (read_done),
    .i_axi_write_done  (write_done),
    .o_axi_read_start  (o_axi_read_start),
    .o_axi_write_start (o_axi_write_start),
    .o_axi_addr        (o_axi_addr),
    .o_icache_done     (o_icache_done),
    .o_dcache_done     (o_dcache_done),
    .o_icache_grant    (o_icache_grant),
    .o_dcache_grant    (o_dcache_grant),
    .o_timeout_err     (o_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick();
    if (i_pend && d_pend) begin
      if (RR && last_win == WHO_D) return WHO_I;
      return WHO_D;
    end
    return d_pend ? WHO_D : WHO_I;
  endfunction

  function automatic logic [63:0] rand_addr();
    return {$urandom, $urandom} & ~64'h3f;
  endfunction

  task automatic raise_i(input logic [63:0] a);
    icache_req  = 1'b1;
    icache_addr = a;
    i_pend      = 1'b1;
  endtask

  task automatic raise_d(input logic we, input logic [63:0] a);
    dcache_req  = 1'b1;
    dcache_we   = we;
    dcache_addr = a;
    d_pend      = 1'b1;
  endtask

  // Entered at the negedge of an IDLE cycle with at least one request raised.
  task automatic do_transfer(input int delay, input bit wrong_done, input bit raise_other);
    int          who;
    bit          wr, err_now;
    logic [63:0] a;
    logic [1:0]  gnt;
    who = model_pick();
    wr  = (who == WHO_D) && dcache_we;
    a   = (who == WHO_D) ? dcache_addr : icache_addr;
    gnt = (who == WHO_I) ? 2'b10 : 2'b01;

    @(negedge clk);
    check("start_rd", o_axi_read_start, !wr);
    check("start_wr", o_axi_write_start, wr);
    check("start_grant", {o_icache_grant, o_dcache_grant}, gnt);
    check("start_addr", o_axi_addr, a);
    last_win = who;

    if (delay == 0) begin
      if (wr) write_done = 1'b1;
      else    read_done  = 1'b1;
    end
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      read_done  = 1'b0;
      write_done = 1'b0;
      check("busy_start", {o_axi_read_start, o_axi_write_start}, 2'b00);
      check("busy_done", {o_icache_done, o_dcache_done}, 2'b00);
      check("busy_grant", {o_icache_grant, o_dcache_grant}, gnt);
      check("busy_addr", o_axi_addr, a);
      check("busy_err", o_timeout_err, exp_err || (k >= TMO));
      if (k == 0 && raise_other) begin
        if (who == WHO_I && !d_pend)      raise_d(1'($urandom_range(1)), rand_addr());
        else if (who == WHO_D && !i_pend) raise_i(rand_addr());
      end
      if (k == delay - 1) begin
        if (wr) write_done = 1'b1;
        else    read_done  = 1'b1;
      end else if (wrong_done && k == 0) begin
        if (wr) read_done  = 1'b1;
        else    write_done = 1'b1;
      end
    end

    @(negedge clk);
    read_done  = 1'b0;
    write_done = 1'b0;
    err_now    = exp_err || (delay >= TMO);
    check("rel_done", {o_icache_done, o_dcache_done}, gnt);
    check("rel_grant", {o_icache_grant, o_dcache_grant}, gnt);
    check("rel_addr", o_axi_addr, a);
    check("rel_err", o_timeout_err, err_now);
    exp_err = err_now;
    if (who == WHO_I) begin
      icache_req = 1'b0;
      i_pend     = 1'b0;
    end else begin
      dcache_req = 1'b0;
      d_pend     = 1'b0;
    end

    @(negedge clk);
    check("idle_grant", {o_icache_grant, o_dcache_grant}, 2'b00);
    check("idle_done", {o_icache_done, o_dcache_done}, 2'b00);
    check("idle_start", {o_axi_read_start, o_axi_write_start}, 2'b00);
    check("idle_err", o_timeout_err, exp_err);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, {o_axi_read_start, o_axi_write_start}, 2'b00);
    check({tag, "_done"}, {o_icache_done, o_dcache_done}, 2'b00);
    check({tag, "_grant"}, {o_icache_grant, o_dcache_grant}, 2'b00);
    check({tag, "_addr"}, o_axi_addr, 64'h0);
    check({tag, "_err"}, o_timeout_err, 1'b0);
  endtask

  initial begin
    arst        = 1'b1;
    icache_req  = 1'b0;
    dcache_req  = 1'b0;
    dcache_we   = 1'b0;
    icache_addr = '0;
    dcache_addr = '0;
    read_done   = 1'b0;
    write_done  = 1'b0;
    i_pend      = 1'b0;
    d_pend      = 1'b0;
    last_win    = WHO_I;
    exp_err     = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    arst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // I-cache refill alone.
    raise_i(64'h1000);
    do_transfer(5, 1'b0, 1'b0);

    // D-cache write-back with a stray read_done that must be ignored.
    raise_d(1'b1, 64'h2040);
    do_transfer(4, 1'b1, 1'b0);

    // Two simultaneous ties: order follows the active policy.
    for (int t = 0; t < 2; t++) begin
      raise_i(64'h3000 + 64'(t));
      raise_d(1'b0, 64'h4000 + 64'(t));
      do_transfer(2, 1'b0, 1'b0);
      do_transfer(1, 1'b0, 1'b0);
    end

    // Random traffic; delays stay under the watchdog limit.
    for (int t = 0; t < 60; t++) begin
      if (!i_pend && !d_pend) begin
        case ($urandom_range(2))
          0:       raise_i(rand_addr());
          1:       raise_d(1'($urandom_range(1)), rand_addr());
          default: begin
            raise_i(rand_addr());
            raise_d(1'($urandom_range(1)), rand_addr());
          end
        endcase
      end
      do_transfer(int'($urandom_range(6)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    while (i_pend || d_pend) do_transfer(1, 1'b0, 1'b0);

    // Watchdog fires after TMO busy cycles, stays set, and a late done still completes.
    raise_i(64'h5000);
    do_transfer(TMO + 6, 1'b0, 1'b0);

    // Reset in the middle of a busy transfer.
    raise_d(1'b0, 64'h6000);
    @(negedge clk);
    check("rst_pre_grant", o_dcache_grant, 1'b1);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    #1;
    check_all_zero("midrst");
    dcache_req = 1'b0;
    d_pend     = 1'b0;
    last_win   = WHO_I;
    exp_err    = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all_zero("after_rst");
    end
    raise_i(64'h7000);
    do_transfer(2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
